mem_stage: RTL and testbench

Memory-access stage of the five-stage RV32I core, sitting directly downstream of the execute stage. It holds the EX/MEM pipeline register, runs the load/store handshake with the data memory, and aligns and sign-extends load data. It drives the MEM/WB pipeline register, forwards results back to execute, and stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/lsu_pkg.sv | 14 +
 rtl/mem_stage_pkg.sv | 74 +++++++
 rtl/lsu_align.sv | 72 +++++++
 rtl/mem_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared types.
// lsuop_t follows the RV32I funct3 encoding: bits [1:0] give the access
// size (byte/half/word) and bit 2 selects zero-extension for loads.
package lsu_pkg;

   typedef enum logic [2:0] {
      LSU_B  = 3'b000,
      LSU_H  = 3'b001,
      LSU_W  = 3'b010,
      LSU_BU = 3'b100,
      LSU_HU = 3'b101
   } lsuop_t;

endpackage

// File: rtl/mem_stage_pkg.sv
// Types shared by the memory-access stage, its lane-alignment helper and
// the neighbouring pipeline stages.
package mem_stage_pkg;

   import lsu_pkg::*;

   // Writeback source select
   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_CSR  = 2'b11;

   // Data-memory handshake state
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10
   } mem_state_t;

   typedef struct packed {
      logic        csr_en;
      logic [1:0]  csr_op;
      logic [11:0] csr_addr;
   } csr_ctrl_t;

   // Execute-stage result bundle (EX/MEM register contents)
   typedef struct packed {
      logic [4:0]  rd;
      logic        rf_en;
      logic [1:0]  wb_sel;
      logic        dm_en;
      logic        dm_we;
      lsuop_t      lsuop;
      logic [31:0] opr_res;
      logic [31:0] opr_b;
      logic [31:0] pc4;
      logic [31:0] zimm;
      csr_ctrl_t   csr;
   } ex_stage_out_t;

   // Forwarding bundle back to execute
   typedef struct packed {
      logic        rf_en;
      logic [4:0]  rd;
      logic [31:0] opr_res;
   } ex_stage_in_frm_mem_t;

   // MEM/WB register contents
   typedef struct packed {
      logic [4:0]  rd;
      logic        rf_en;
      logic [1:0]  wb_sel;
      logic [31:0] opr_res;
      logic [31:0] load_data;
      logic [31:0] pc4;
      logic [31:0] zimm;
      csr_ctrl_t   csr;
   } mem_stage_out_t;

   // Access size: 00 byte, 01 half, 1x word
   function automatic logic [1:0] lsu_size(input lsuop_t op);
      logic [2:0] bits_v;
      bits_v = op;
      return bits_v[1:0];
   endfunction

   // Loads with this bit set are zero-extended
   function automatic logic lsu_unsigned(input lsuop_t op);
      logic [2:0] bits_v;
      bits_v = op;
      return bits_v[2];
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the data-memory port: byte enables, store-data
// replication and load extraction with sign/zero extension. Address bits
// below the access size are ignored, so a half access uses lane 0 or 2
// and a word access always uses lane 0.
module lsu_align
   import lsu_pkg::*;
   import mem_stage_pkg::*;
(
   input  lsuop_t      lsuop,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [1:0]  size_s;
   logic [1:0]  lane_s;
   logic [31:0] shifted_s;

   // Lane choice, byte enables and replicated store data
   always_comb begin
      size_s = lsu_size(lsuop);
      lane_s = 2'b00;
      be     = 4'b1111;
      wdata  = store_data;
      case (size_s)
         2'b00: begin
            lane_s = addr_lo;
            be     = 4'b0001 << lane_s;
            wdata  = {4{store_data[7:0]}};
         end
         2'b01: begin
            lane_s = {addr_lo[1], 1'b0};
            be     = 4'b0011 << lane_s;
            wdata  = {2{store_data[15:0]}};
         end
         default: begin
            lane_s = 2'b00;
            be     = 4'b1111;
            wdata  = store_data;
         end
      endcase
   end

   // Shift the addressed lane down to bit 0 and extend it to 32 bits
   always_comb begin
      shifted_s = rdata >> {lane_s, 3'b000};
      load_data = shifted_s;
      case (size_s)
         2'b00: begin
            if (lsu_unsigned(lsuop)) begin
               load_data = {24'h000000, shifted_s[7:0]};
            end else begin
               load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
         end
         2'b01: begin
            if (lsu_unsigned(lsuop)) begin
               load_data = {16'h0000, shifted_s[15:0]};
            end else begin
               load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
         end
         default: begin
            load_data = shifted_s;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: EX/MEM register, data-memory
// handshake FSM, load alignment, MEM/WB register and forwarding to execute.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word
// accesses are trapped instead of issued to memory).
module mem_stage
   import lsu_pkg::*;
   import mem_stage_pkg::*;
#(
   parameter int DMEM_AW = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  ex_stage_out_t        ex_i,
   input  logic                 flush,
   output logic                 stall_o,
   output ex_stage_in_frm_mem_t fwd_o,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [DMEM_AW-1:0]   dmem_addr,
   output logic [31:0]          dmem_wdata,
   output logic [3:0]           dmem_be,
   input  logic                 dmem_gnt,
   input  logic                 dmem_rvalid,
   input  logic [31:0]          dmem_rdata,
   output logic                 out_valid,
   output mem_stage_out_t       wb_o,
   output logic                 misalign_o
);

   logic           ex_valid_r;
   ex_stage_out_t  ex_r;
   mem_state_t     state_r;
   mem_state_t     state_nxt_s;
   logic           kill_r;
   logic           kill_nxt_s;
   logic           done_s;
   logic           mem_op_s;
   logic           misalign_s;
   logic           commit_s;
   logic [3:0]     be_s;
   logic [31:0]    wdata_s;
   logic [31:0]    load_data_s;
   mem_stage_out_t wb_nxt_s;
   mem_stage_out_t wb_r;
   logic           out_valid_r;

   lsu_align u_lsu_align (
      .lsuop      (ex_r.lsuop),
      .addr_lo    (ex_r.opr_res[1:0]),
      .store_data (ex_r.opr_b),
      .rdata      (dmem_rdata),
      .be         (be_s),
      .wdata      (wdata_s),
      .load_data  (load_data_s)
   );

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign_r;

   // Detect half/word accesses whose address is not size-aligned
   always_comb begin
      misalign_s = 1'b0;
      if (ex_valid_r && ex_r.dm_en) begin
         case (lsu_size(ex_r.lsuop))
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = ex_r.opr_res[0];
            default: misalign_s = |ex_r.opr_res[1:0];
         endcase
      end else begin
         misalign_s = 1'b0;
      end
   end

   // One-cycle trap pulse, aligned with the bubble written to MEM/WB
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_r <= 1'b0;
      end else begin
         misalign_r <= misalign_s & ~flush;
      end
   end

   assign misalign_o = misalign_r;
`else
   assign misalign_s = 1'b0;
   assign misalign_o = 1'b0;
`endif

   assign mem_op_s = ex_valid_r & ex_r.dm_en & ~misalign_s;

   // EX/MEM register; frozen while an access is outstanding
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_r <= 1'b0;
         ex_r       <= '0;
      end else if (!stall_o) begin
         ex_valid_r <= in_valid;
         ex_r       <= ex_i;
      end
   end

   // Handshake state and flushed-load marker
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         kill_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         kill_r  <= kill_nxt_s;
      end
   end

   // Next-state, request and completion decode
   always_comb begin
      state_nxt_s = state_r;
      kill_nxt_s  = kill_r;
      done_s      = 1'b0;
      dmem_req    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            kill_nxt_s = 1'b0;
            if (mem_op_s) begin
               dmem_req = 1'b1;
               if (dmem_gnt) begin
                  if (ex_r.dm_we) begin
                     done_s = 1'b1;
                  end else begin
                     state_nxt_s = ST_WAIT;
                     kill_nxt_s  = flush;
                  end
               end else if (flush) begin
                  done_s = 1'b1;
               end else begin
                  state_nxt_s = ST_REQ;
               end
            end else begin
               done_s = 1'b1;
            end
         end
         ST_REQ: begin
            dmem_req = 1'b1;
            if (dmem_gnt) begin
               if (ex_r.dm_we) begin
                  state_nxt_s = ST_IDLE;
                  done_s      = 1'b1;
               end else begin
                  state_nxt_s = ST_WAIT;
                  kill_nxt_s  = flush;
               end
            end else if (flush) begin
               // Ungranted request is simply withdrawn
               state_nxt_s = ST_IDLE;
               done_s      = 1'b1;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            // A granted load must still drain its response
            if (flush) begin
               kill_nxt_s = 1'b1;
            end else begin
               kill_nxt_s = kill_r;
            end
            if (dmem_rvalid) begin
               state_nxt_s = ST_IDLE;
               done_s      = 1'b1;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            kill_nxt_s  = 1'b0;
            done_s      = 1'b0;
         end
      endcase
   end

   assign stall_o    = ex_valid_r & ex_r.dm_en & ~done_s;
   assign dmem_addr  = {ex_r.opr_res[DMEM_AW-1:2], 2'b00};
   assign dmem_wdata = wdata_s;

   // Write strobe and byte enables only qualify a live request
   always_comb begin
      if (dmem_req) begin
         dmem_we = ex_r.dm_we;
         dmem_be = be_s;
      end else begin
         dmem_we = 1'b0;
         dmem_be = 4'b0000;
      end
   end

   assign commit_s = done_s & ex_valid_r & ~flush & ~kill_r & ~misalign_s;

   // Build the next MEM/WB contents; anything not committing becomes a bubble
   always_comb begin
      wb_nxt_s = '0;
      if (commit_s) begin
         wb_nxt_s.rd      = ex_r.rd;
         wb_nxt_s.rf_en   = ex_r.rf_en;
         wb_nxt_s.wb_sel  = ex_r.wb_sel;
         wb_nxt_s.opr_res = ex_r.opr_res;
         wb_nxt_s.pc4     = ex_r.pc4;
         wb_nxt_s.zimm    = ex_r.zimm;
         wb_nxt_s.csr     = ex_r.csr;
         if (state_r == ST_WAIT) begin
            wb_nxt_s.load_data = load_data_s;
         end else begin
            wb_nxt_s.load_data = 32'h00000000;
         end
      end else begin
         wb_nxt_s = '0;
      end
   end

   // MEM/WB pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_r        <= '0;
         out_valid_r <= 1'b0;
      end else begin
         wb_r        <= wb_nxt_s;
         out_valid_r <= commit_s;
      end
   end

   assign wb_o      = wb_r;
   assign out_valid = out_valid_r;

   // Forward ALU-class results; load data is never forwarded from here
   always_comb begin
      fwd_o.rf_en   = ex_valid_r & ex_r.rf_en & (ex_r.wb_sel != WB_LOAD);
      fwd_o.rd      = ex_r.rd;
      fwd_o.opr_res = ex_r.opr_res;
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with an expected-writeback
// queue: entries are pushed when an instruction is driven and popped when
// out_valid is seen.
module tb_mem_stage;

   import lsu_pkg::*;
   import mem_stage_pkg::*;

   localparam int DMEM_AW = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   ex_stage_out_t        ex_i;
   logic                 flush;
   logic                 stall_o;
   ex_stage_in_frm_mem_t fwd_o;
   logic                 dmem_req;
   logic                 dmem_we;
   logic [DMEM_AW-1:0]   dmem_addr;
   logic [31:0]          dmem_wdata;
   logic [3:0]           dmem_be;
   logic                 dmem_gnt;
   logic                 dmem_rvalid;
   logic [31:0]          dmem_rdata;
   logic                 out_valid;
   mem_stage_out_t       wb_o;
   logic                 misalign_o;

   int checks = 0;
   int errors = 0;
   mem_stage_out_t exp_q[$];

   always #5 clk = ~clk;

   mem_stage #(.DMEM_AW(DMEM_AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .ex_i(ex_i), .flush(flush),
      .stall_o(stall_o), .fwd_o(fwd_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .out_valid(out_valid), .wb_o(wb_o), .misalign_o(misalign_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_wb(input string tag, input mem_stage_out_t obs, input mem_stage_out_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic ex_stage_out_t mk_ex(input logic dm_en, input logic we, input lsuop_t op,
                                           input logic [1:0] wbs, input logic [4:0] rd,
                                           input logic [31:0] res, input logic [31:0] b);
      ex_stage_out_t e;
      e = '0;
      e.rd = rd;  e.rf_en = (rd != 5'd0);  e.wb_sel = wbs;
      e.dm_en = dm_en;  e.dm_we = we;  e.lsuop = op;
      e.opr_res = res;  e.opr_b = b;  e.pc4 = res + 32'd4;  e.zimm = 32'h0000001F;
      e.csr.csr_en = 1'b1;  e.csr.csr_op = 2'b10;  e.csr.csr_addr = 12'h305;
      return e;
   endfunction

   function automatic mem_stage_out_t exp_wb(input ex_stage_out_t e, input logic [31:0] ld);
      mem_stage_out_t w;
      w.rd = e.rd;  w.rf_en = e.rf_en;  w.wb_sel = e.wb_sel;  w.opr_res = e.opr_res;
      w.load_data = ld;  w.pc4 = e.pc4;  w.zimm = e.zimm;  w.csr = e.csr;
      return w;
   endfunction

   // Advance one clock; compare any produced writeback against the queue
   task automatic tick();
      mem_stage_out_t e;
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_out_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk_wb("sb_wb", wb_o, e);
         end
      end
   endtask

   // Load with immediate grant and data on the following cycle
   task automatic run_load(input string tag, input lsuop_t op, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp_data);
      ex_stage_out_t e;
      e = mk_ex(1'b1, 1'b0, op, WB_LOAD, 5'd3, addr, 32'h0);
      in_valid = 1'b1;  ex_i = e;
      exp_q.push_back(exp_wb(e, exp_data));
      tick();                                   // edge 1: EX/MEM loaded
      in_valid = 1'b0;  ex_i = '0;  dmem_gnt = 1'b1;
      #1;
      chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
      chk({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
      chk({tag, "_addr"}, dmem_addr, addr & 32'hFFFFFFFC);
      chk({tag, "_fwd_en"}, {31'd0, fwd_o.rf_en}, 32'd0);
      tick();                                   // edge 2: into WAIT
      dmem_gnt = 1'b0;  dmem_rvalid = 1'b1;  dmem_rdata = word;
      #1;
      chk({tag, "_nostall"}, {31'd0, stall_o}, 32'd0);
      chk({tag, "_req_low"}, {31'd0, dmem_req}, 32'd0);
      tick();                                   // edge 3: MEM/WB written
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      dmem_rvalid = 1'b0;  dmem_rdata = 32'h0;
   endtask

   initial begin
      ex_stage_out_t e;
      rst = 1'b1;  in_valid = 1'b0;  ex_i = '0;  flush = 1'b0;
      dmem_gnt = 1'b0;  dmem_rvalid = 1'b0;  dmem_rdata = 32'h0;
      tick();
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_we", {31'd0, dmem_we}, 32'd0);
      chk("rst_be", {28'd0, dmem_be}, 32'd0);
      chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
      chk("rst_fwd_en", {31'd0, fwd_o.rf_en}, 32'd0);
      chk_wb("rst_wb", wb_o, '0);
      rst = 1'b0;

      // ALU op: forwarded in the same cycle, no memory request
      e = mk_ex(1'b0, 1'b0, LSU_W, WB_ALU, 5'd5, 32'd7, 32'h0);
      in_valid = 1'b1;  ex_i = e;  exp_q.push_back(exp_wb(e, 32'h0));
      tick();
      in_valid = 1'b0;  ex_i = '0;
      #1;
      chk("alu_fwd", {fwd_o.rf_en, fwd_o.rd, fwd_o.opr_res[25:0]}, {1'b1, 5'd5, 26'd7});
      chk("alu_req", {31'd0, dmem_req}, 32'd0);
      chk("alu_stall", {31'd0, stall_o}, 32'd0);
      tick();
      chk("alu_out_valid", {31'd0, out_valid}, 32'd1);

      // Loads of each width and signedness
      run_load("lw",  LSU_W,  32'h00000100, 32'hDEADBEEF, 32'hDEADBEEF);
      run_load("lb",  LSU_B,  32'h00000103, 32'h80123456, 32'hFFFFFF80);
      run_load("lbu", LSU_BU, 32'h00000103, 32'h80123456, 32'h00000080);
      run_load("lh",  LSU_H,  32'h00000102, 32'h80015A5A, 32'hFFFF8001);
      run_load("lhu", LSU_HU, 32'h00000202, 32'h80015A5A, 32'h00008001);
      run_load("lb1", LSU_B,  32'h00000101, 32'h11227F44, 32'h0000007F);

`ifndef MEM_MISALIGN_TRAP_EN
      // Without the trap, sub-size address bits are ignored
      run_load("lh_odd", LSU_H, 32'h00000103, 32'hABCD1234, 32'hFFFFABCD);
      run_load("lw_odd", LSU_W, 32'h00000101, 32'hCAFEF00D, 32'hCAFEF00D);
      chk("no_misalign", {31'd0, misalign_o}, 32'd0);
`else
      e = mk_ex(1'b1, 1'b0, LSU_W, WB_LOAD, 5'd3, 32'h00000101, 32'h0);
      in_valid = 1'b1;  ex_i = e;
      tick();
      in_valid = 1'b0;  ex_i = '0;
      #1;
      chk("mis_req", {31'd0, dmem_req}, 32'd0);
      chk("mis_stall", {31'd0, stall_o}, 32'd0);
      tick();
      chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
      chk("mis_bubble", {31'd0, out_valid}, 32'd0);
      tick();
      chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
`endif

      // Store half with grant arriving on the fourth request cycle
      e = mk_ex(1'b1, 1'b1, LSU_H, WB_ALU, 5'd0, 32'h00000202, 32'h00001234);
      in_valid = 1'b1;  ex_i = e;  exp_q.push_back(exp_wb(e, 32'h0));
      tick();
      in_valid = 1'b0;  ex_i = '0;
      for (int i = 0; i < 4; i++) begin
         dmem_gnt = (i == 3);
         #1;
         chk("sh_req", {31'd0, dmem_req}, 32'd1);
         chk("sh_we", {31'd0, dmem_we}, 32'd1);
         chk("sh_addr", dmem_addr, 32'h00000200);
         chk("sh_be", {28'd0, dmem_be}, 32'h0000000C);
         chk("sh_wdata", dmem_wdata, 32'h12341234);
         chk("sh_stall", {31'd0, stall_o}, (i < 3) ? 32'd1 : 32'd0);
         tick();
      end
      dmem_gnt = 1'b0;
      chk("sh_req_done", {31'd0, dmem_req}, 32'd0);

      // Flush while waiting for load data: response consumed, bubble written
      e = mk_ex(1'b1, 1'b0, LSU_W, WB_LOAD, 5'd9, 32'h00000300, 32'h0);
      in_valid = 1'b1;  ex_i = e;
      tick();
      in_valid = 1'b0;  ex_i = '0;  dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;  flush = 1'b1;
      #1;
      chk("fw_stall", {31'd0, stall_o}, 32'd1);
      tick();
      flush = 1'b0;
      #1;
      chk("fw_still_wait", {31'd0, stall_o}, 32'd1);
      dmem_rvalid = 1'b1;  dmem_rdata = 32'h55AA55AA;
      #1;
      chk("fw_release", {31'd0, stall_o}, 32'd0);
      tick();
      dmem_rvalid = 1'b0;
      chk("fw_bubble", {31'd0, out_valid}, 32'd0);

      // Flush while the request is pending: request withdrawn
      e = mk_ex(1'b1, 1'b1, LSU_W, WB_ALU, 5'd0, 32'h00000500, 32'hA5A5A5A5);
      in_valid = 1'b1;  ex_i = e;
      tick();
      in_valid = 1'b0;  ex_i = '0;
      tick();
      flush = 1'b1;
      #1;
      chk("fr_stall", {31'd0, stall_o}, 32'd0);
      tick();
      flush = 1'b0;
      #1;
      chk("fr_req", {31'd0, dmem_req}, 32'd0);
      chk("fr_bubble", {31'd0, out_valid}, 32'd0);

      // Reset in REQ abandons the access
      e = mk_ex(1'b1, 1'b1, LSU_W, WB_ALU, 5'd0, 32'h00000400, 32'h01020304);
      in_valid = 1'b1;  ex_i = e;
      tick();
      in_valid = 1'b0;  ex_i = '0;
      tick();
      #1;
      chk("rr_req_before", {31'd0, dmem_req}, 32'd1);
      rst = 1'b1;
      tick();
      chk("rr_req", {31'd0, dmem_req}, 32'd0);
      chk("rr_we", {31'd0, dmem_we}, 32'd0);
      chk("rr_be", {28'd0, dmem_be}, 32'd0);
      chk("rr_stall", {31'd0, stall_o}, 32'd0);
      chk("rr_out_valid", {31'd0, out_valid}, 32'd0);
      chk_wb("rr_wb", wb_o, '0);
      rst = 1'b0;

      // Stray gnt/rvalid with nothing outstanding are ignored
      dmem_gnt = 1'b1;  dmem_rvalid = 1'b1;
      tick();
      dmem_gnt = 1'b0;  dmem_rvalid = 1'b0;
      tick();
      chk("stray_out_valid", {31'd0, out_valid}, 32'd0);
      chk("stray_req", {31'd0, dmem_req}, 32'd0);

      // PC+4 writeback after all of the above still flows normally
      e = mk_ex(1'b0, 1'b0, LSU_W, WB_PC4, 5'd1, 32'h00000080, 32'h0);
      in_valid = 1'b1;  ex_i = e;  exp_q.push_back(exp_wb(e, 32'h0));
      tick();
      in_valid = 1'b0;  ex_i = '0;
      #1;
      chk("pc4_fwd_en", {31'd0, fwd_o.rf_en}, 32'd1);
      tick();
      tick();

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
